// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the stack request front end.
//   state_t  : controller FSM states (IDLE accepts, READ waits on RAM, RESP offers the pop result)
//   OP_PUSH / OP_POP : encodings carried on req_op
package stack_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

endpackage

// File: rtl/stack_ctrl_if.sv
// Command/response bundle between the control unit and the stack front end.
//   req_valid/req_ready/req_op/req_data : command channel (control unit -> stack)
//   rsp_valid/rsp_ready/rsp_data/rsp_err: pop response channel (stack -> control unit)
// Handshake rule for both channels: a transfer happens on a rising clock edge where
// valid and ready are both 1; once valid is raised the sender holds it and its payload
// stable until that transfer, and ready may be raised or lowered at any time.
interface stack_ctrl_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_op;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  // Control unit side
  modport master (
    output req_valid, req_op, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  // Stack front end side
  modport slave (
    input  req_valid, req_op, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/stack_ctrl.sv
// Request-level front end for the hardware stack.
// Accepts push/pop commands, strobes the external stack pointer, drives the synchronous
// stack RAM and returns popped words over the response channel. Keeps its own occupancy
// count so that overflow/underflow are caught even though the pointer wraps silently.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   bus (slave)     : command/response handshake bundle
//   sp_push/sp_pop  : stack pointer strobes (never both high)
//   sp_addr         : pointer address (free slot for push, top entry for pop)
//   mem_we/mem_addr/mem_wdata/mem_rdata : RAM port, read data one cycle after address
//   depth/full/empty: occupancy 0..DEPTH and its decodes
//   ovf/unf/clr_err : sticky overflow/underflow flags and their synchronous clear
//   state_dbg       : current FSM state
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  stack_ctrl_if.slave           bus,
  output logic                  sp_push,
  output logic                  sp_pop,
  input  logic [ADDR_WIDTH-1:0] sp_addr,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH:0]   depth,
  output logic                  full,
  output logic                  empty,
  output logic                  ovf,
  output logic                  unf,
  input  logic                  clr_err,
  output state_t                state_dbg
);

  localparam logic [ADDR_WIDTH:0] DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] DEPTH_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   depth_q, depth_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;

  logic accept;
  logic is_push, is_pop;
  logic push_ok, push_bad, pop_ok, pop_bad;

  always_comb begin
    full  = (depth_q == DEPTH);
    empty = (depth_q == '0);

    accept   = bus.req_valid && (state_q == S_IDLE);
    is_push  = accept && (bus.req_op == OP_PUSH);
    is_pop   = accept && (bus.req_op == OP_POP);
    push_ok  = is_push && !full;
    push_bad = is_push && full;
    pop_ok   = is_pop && !empty;
    pop_bad  = is_pop && empty;

    // Strobes are purely combinational from an accepted, legal command.
    sp_push   = push_ok;
    sp_pop    = pop_ok;
    mem_we    = push_ok;
    mem_addr  = sp_addr;
    mem_wdata = bus.req_data;

    bus.req_ready = (state_q == S_IDLE);
    bus.rsp_valid = (state_q == S_RESP);
    bus.rsp_data  = rsp_data_q;
    bus.rsp_err   = rsp_err_q;

    depth     = depth_q;
    ovf       = ovf_q;
    unf       = unf_q;
    state_dbg = state_q;
  end

  // Next state, occupancy, flags and response payload.
  always_comb begin
    state_d    = state_q;
    depth_d    = depth_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    // Clear first, so a same-cycle error set below takes priority.
    ovf_d = clr_err ? 1'b0 : ovf_q;
    unf_d = clr_err ? 1'b0 : unf_q;
    if (push_bad) ovf_d = 1'b1;
    if (pop_bad)  unf_d = 1'b1;

    if (push_ok) depth_d = depth_q + DEPTH_ONE;
    if (pop_ok)  depth_d = depth_q - DEPTH_ONE;

    case (state_q)
      S_IDLE: begin
        if (pop_ok) begin
          state_d = S_READ;
        end else if (pop_bad) begin
          // Underflow skips the RAM read and answers immediately.
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_READ: begin
        rsp_data_d = mem_rdata;
        rsp_err_d  = 1'b0;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      depth_q    <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      depth_q    <= depth_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with ADDR_WIDTH=3 / DATA_WIDTH=8, including behavioural
// models of the stack pointer (starts at 7, moves down on push) and a synchronous RAM.
module tb_stack_ctrl;
  import stack_ctrl_pkg::*;

  localparam int AW = 3;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT and models ----------------
  stack_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  logic          sp_push, sp_pop, mem_we, full, empty, ovf, unf, clr_err;
  logic [AW-1:0] sp_addr, mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [AW:0]   depth;
  state_t        state_dbg;

  stack_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .sp_push(sp_push), .sp_pop(sp_pop), .sp_addr(sp_addr),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .depth(depth), .full(full), .empty(empty), .ovf(ovf), .unf(unf),
    .clr_err(clr_err), .state_dbg(state_dbg)
  );

  // Stack pointer model: sp_q is the free slot; the top entry sits one above it.
  logic [AW-1:0] sp_q;
  always @(posedge clk or posedge rst) begin
    if (rst)          sp_q <= 3'd7;
    else if (sp_push) sp_q <= sp_q - 3'd1;
    else if (sp_pop)  sp_q <= sp_q + 3'd1;
  end
  assign sp_addr = sp_pop ? (sp_q + 3'd1) : sp_q;

  // Synchronous RAM model.
  logic [DW-1:0] ram [8];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];   // LIFO model of stack contents
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one word; exp_addr is the slot the write must land in (ignored when full).
  task automatic do_push(input logic [DW-1:0] d, input logic [AW-1:0] exp_addr);
    bit full_now;
    full_now = (exp_q.size() == 8);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_PUSH;
    bus.req_data  = d;
    @(negedge clk);
    check("push_sp_push", sp_push, !full_now);
    check("push_mem_we", mem_we, !full_now);
    if (!full_now) begin
      check("push_mem_addr", mem_addr, exp_addr);
      check("push_mem_wdata", mem_wdata, d);
    end
    tick();
    bus.req_valid = 1'b0;
    if (!full_now) exp_q.push_back(d);
    check("push_depth", depth, exp_q.size());
  endtask

  // Pop one word and wait (bounded) for the response; returns one cycle into RESP
  // consumption, i.e. back in IDLE if rsp_ready was high.
  task automatic do_pop();
    bit            err_case;
    logic [DW-1:0] exp_d;
    int            lat;
    err_case = (exp_q.size() == 0);
    exp_d    = err_case ? 8'h00 : exp_q.pop_back();
    bus.req_valid = 1'b1;
    bus.req_op    = OP_POP;
    @(negedge clk);
    check("pop_sp_pop", sp_pop, !err_case);
    check("pop_mem_we", mem_we, 1'b0);
    tick();
    bus.req_valid = 1'b0;
    check("pop_depth", depth, exp_q.size());
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat = i;
        break;
      end
    end
    check("pop_latency", lat, err_case ? 1 : 2);
    check("pop_rsp_data", bus.rsp_data, exp_d);
    check("pop_rsp_err", bus.rsp_err, err_case);
    tick();
  endtask

  task automatic pulse_clr(input logic also_err_push);
    clr_err = 1'b1;
    if (also_err_push) begin
      bus.req_valid = 1'b1;
      bus.req_op    = OP_PUSH;
      bus.req_data  = 8'hEE;
    end
    tick();
    clr_err = 1'b0;
    bus.req_valid = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit       saw_valid;
    logic [DW-1:0] held;
    bus.req_valid = 1'b0;
    bus.req_op    = OP_PUSH;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b1;
    clr_err       = 1'b0;

    // 1: reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("rst_depth", depth, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_unf", unf, 0);
    check("rst_state", state_dbg, S_IDLE);

    // 2: back-to-back pushes to 7,6,5, then three pops in LIFO order
    do_push(8'h11, 3'd7);
    do_push(8'h22, 3'd6);
    do_push(8'h33, 3'd5);
    check("t2_depth3", depth, 3);
    repeat (3) do_pop();
    check("t2_empty", empty, 1);

    // 3: fill to capacity, overflow attempt, clear, set-wins-over-clear, drain
    for (int i = 0; i < 8; i++) do_push(8'hA0 + 8'(i), 3'(7 - i));
    check("t3_full", full, 1);
    check("t3_empty", empty, 0);
    check("t3_depth8", depth, 8);
    do_push(8'hFF, 3'd0);
    check("t3_ovf_set", ovf, 1);
    check("t3_depth_hold", depth, 8);
    pulse_clr(1'b0);
    check("t3_ovf_clr", ovf, 0);
    pulse_clr(1'b1);
    check("t3_ovf_set_wins", ovf, 1);
    pulse_clr(1'b0);
    check("t3_ovf_clr2", ovf, 0);
    repeat (8) do_pop();
    check("t3_drained", empty, 1);
    check("t3_unf_clean", unf, 0);

    // 4: pop while empty
    do_pop();
    check("t4_unf", unf, 1);
    check("t4_depth", depth, 0);
    pulse_clr(1'b0);
    check("t4_unf_clr", unf, 0);

    // 5: response held off by rsp_ready low
    do_push(8'h5A, 3'd7);
    bus.rsp_ready = 1'b0;
    do_pop();
    held = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_hold_valid", bus.rsp_valid, 1);
      check("t5_hold_data", bus.rsp_data, held);
      check("t5_hold_ready", bus.req_ready, 0);
    end
    tick();
    bus.rsp_ready = 1'b1;
    tick();
    check("t5_idle_ready", bus.req_ready, 1);
    check("t5_idle_valid", bus.rsp_valid, 0);

    // 6: reset while in READ discards the response
    do_push(8'hC3, 3'd7);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_POP;
    tick();
    bus.req_valid = 1'b0;
    check("t6_in_read", state_dbg, S_READ);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("t6_rst_depth", depth, 0);
    check("t6_rst_valid", bus.rsp_valid, 0);
    tick();
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) saw_valid = 1'b1;
    end
    check("t6_no_rsp", saw_valid, 0);
    tick();
    do_push(8'h77, 3'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
